// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl
//   Sequences the duty word that feeds the servo PWM generator. A target
//   position arrives over a valid/ready handshake. duty_out then slews toward
//   that target in fixed steps, one step per programmable tick. Once the
//   target is reached, the block holds for HOLD_CYCLES clocks and then pulses
//   done.
//
// Build option
//   SERVO_LIMIT_EN  when defined, each accepted target is clamped to
//                   [MIN_DUTY, MAX_DUTY], and limit_hit reports whether the
//                   clamp was applied. When undefined, the target is latched
//                   as given and limit_hit stays 0.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   command accepted this cycle when high with cmd_valid (IDLE, not in reset)
//   cmd_target  target duty word
//   rate_div    tick period minus one, in clk cycles
//   step        duty increment per tick (0 is treated as 1)
//   abort       stop motion in RAMP/HOLD, freeze duty_out, no done pulse
//   duty_out    duty word to the PWM block
//   busy        controller is not IDLE
//   done        one-cycle pulse when HOLD completes
//   limit_hit   last accepted target was clamped
module servo_ramp_ctrl #(
    parameter int CANT_BITS   = 8,
    parameter int DIV_W       = 16,
    parameter int STEP_W      = 4,
    parameter int RESET_DUTY  = 128,
    parameter int HOLD_CYCLES = 1000,
    parameter int MIN_DUTY    = 20,
    parameter int MAX_DUTY    = 235
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CANT_BITS-1:0] cmd_target,
    input  logic [DIV_W-1:0]     rate_div,
    input  logic [STEP_W-1:0]    step,
    input  logic                 abort,
    output logic [CANT_BITS-1:0] duty_out,
    output logic                 busy,
    output logic                 done,
    output logic                 limit_hit
);

`ifdef SERVO_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CMP_W  = (CANT_BITS + 1 > STEP_W) ? CANT_BITS + 1 : STEP_W;

    localparam logic [CANT_BITS-1:0] RESET_Q   = CANT_BITS'(RESET_DUTY);
    localparam logic [CANT_BITS-1:0] MIN_Q     = CANT_BITS'(MIN_DUTY);
    localparam logic [CANT_BITS-1:0] MAX_Q     = CANT_BITS'(MAX_DUTY);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CANT_BITS-1:0]  duty_nxt;
    logic [CANT_BITS-1:0]  target_q, target_nxt;
    logic [DIV_W-1:0]      div_q, div_nxt;
    logic [STEP_W-1:0]     step_q, step_nxt;
    logic [DIV_W-1:0]      tick_cnt, tick_nxt;
    logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
    logic                  done_nxt;
    logic                  limit_nxt;
    logic                  accept;

    logic signed [CANT_BITS:0] diff;
    logic [CANT_BITS:0]        mag;
    logic [CANT_BITS-1:0]      step_c;
    logic                      final_step;

    // Saturate a requested target into the allowed servo travel.
    function automatic logic [CANT_BITS-1:0] clamp_target(input logic [CANT_BITS-1:0] t);
        if (LIMIT_EN && (t < MIN_Q)) return MIN_Q;
        if (LIMIT_EN && (t > MAX_Q)) return MAX_Q;
        return t;
    endfunction

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // The distance is computed one bit wider and signed, so it cannot wrap.
    // If the remaining distance fits in one step, the next tick lands
    // exactly on the target. This prevents overshoot and wrap past the rails.
    assign diff       = $signed({1'b0, target_q}) - $signed({1'b0, duty_out});
    assign mag        = diff[CANT_BITS] ? $unsigned(-diff) : $unsigned(diff);
    assign step_c     = CANT_BITS'(step_q);
    assign final_step = (CMP_W'(mag) <= CMP_W'(step_q));

    always_comb begin
        state_nxt  = state;
        duty_nxt   = duty_out;
        target_nxt = target_q;
        div_nxt    = div_q;
        step_nxt   = step_q;
        tick_nxt   = tick_cnt;
        hold_nxt   = hold_cnt;
        done_nxt   = 1'b0;
        limit_nxt  = limit_hit;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    target_nxt = clamp_target(cmd_target);
                    div_nxt    = rate_div;
                    step_nxt   = (step == '0) ? STEP_W'(1) : step;
                    limit_nxt  = (target_nxt != cmd_target);
                    tick_nxt   = '0;
                    hold_nxt   = '0;
                    state_nxt  = (target_nxt == duty_out) ? S_HOLD : S_RAMP;
                end
            end
            S_RAMP: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (tick_cnt == div_q) begin
                    tick_nxt = '0;
                    if (final_step) begin
                        duty_nxt  = target_q;
                        hold_nxt  = '0;
                        state_nxt = S_HOLD;
                    end else if (diff[CANT_BITS]) begin
                        duty_nxt = duty_out - step_c;
                    end else begin
                        duty_nxt = duty_out + step_c;
                    end
                end else begin
                    tick_nxt = tick_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control and output registers: these return to their reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            duty_out  <= RESET_Q;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            done      <= 1'b0;
            limit_hit <= 1'b0;
        end else begin
            state     <= state_nxt;
            duty_out  <= duty_nxt;
            tick_cnt  <= tick_nxt;
            hold_cnt  <= hold_nxt;
            done      <= done_nxt;
            limit_hit <= limit_nxt;
        end
    end

    // Latched command fields. These are only read after a new accept.
    always_ff @(posedge clk) begin
        target_q <= target_nxt;
        div_q    <= div_nxt;
        step_q   <= step_nxt;
    end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench for servo_ramp_ctrl. Expected duty changes and done
// pulses are queued with their expected cycle spacing. The negedge monitor
// compares every observed event against the queue head. SERVO_LIMIT_EN
// selects the clamped expectations.
module tb_servo_ramp_ctrl;

    localparam int HOLD    = 10;
    localparam int DONE_EV = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cmd_target = 8'd0;
    logic [15:0] rate_div = 16'd0;
    logic [3:0]  step = 4'd0;
    logic        cmd_ready, busy, done, limit_hit;
    logic [7:0]  duty_out;

    servo_ramp_ctrl #(
        .CANT_BITS(8), .DIV_W(16), .STEP_W(4), .RESET_DUTY(128),
        .HOLD_CYCLES(HOLD), .MIN_DUTY(20), .MAX_DUTY(235)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .rate_div(rate_div), .step(step), .abort(abort),
        .duty_out(duty_out), .busy(busy), .done(done), .limit_hit(limit_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int gap;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    int  cur = 128;
    int  prev_duty = 128;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int clamp_model(input int t);
`ifdef SERVO_LIMIT_EN
        if (t < 20) return 20;
        if (t > 235) return 235;
`endif
        return t;
    endfunction

    task automatic push(input int v, input int g);
        ev_t e;
        e.val = v;
        e.gap = g;
        exp_q.push_back(e);
    endtask

    // Reference slew: duty steps toward the target and lands exactly on it.
    task automatic push_ramp(input int tgt, input int div, input int stp);
        int t, s, d;
        t = clamp_model(tgt);
        s = (stp == 0) ? 1 : stp;
        while (cur != t) begin
            d = t - cur;
            if (d <= s && d >= -s) cur = t;
            else if (d > 0)        cur = cur + s;
            else                   cur = cur - s;
            push(cur, div + 1);
        end
        push(DONE_EV, HOLD);
    endtask

    task automatic take_event(input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", val, -1);
            return;
        end
        e = exp_q.pop_front();
        check_eq("sb_value", val, e.val);
        if (e.gap >= 0) check_eq("sb_gap", cyc - last_cyc, e.gap);
        last_cyc = cyc;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(duty_out) != prev_duty) begin
                prev_duty = int'(duty_out);
                take_event(prev_duty);
            end
            if (done) take_event(DONE_EV);
        end
    end

    task automatic send_cmd(input int tgt, input int div, input int stp);
        int n;
        n = 0;
        @(negedge clk);
        cmd_target = 8'(tgt);
        rate_div   = 16'(div);
        step       = 4'(stp);
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        last_cyc  = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, int'(busy), 0);
    endtask

    task automatic wait_duty(input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(duty_out) != v && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_duty", int'(duty_out), v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if (cur != 128) push(128, -1);
        @(negedge clk);
        rst = 1'b0;
        cur = 128;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_duty", int'(duty_out), 128);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_ready", int'(cmd_ready), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_limit", int'(limit_hit), 0);
        rst       = 1'b0;
        prev_duty = 128;
        mon_en    = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", int'(cmd_ready), 1);

        // Slow ramp up: one step every rate_div+1 clocks, last step trimmed.
        push(132, 4); push(136, 4); push(138, 4); push(DONE_EV, HOLD);
        send_cmd(138, 3, 4);
        cur = 138;
        check_eq("s1_busy", int'(busy), 1);
        check_eq("s1_ready_low", int'(cmd_ready), 0);
        wait_idle("s1_idle");
        check_eq("s1_done", int'(done), 1);
        check_eq("s1_ready", int'(cmd_ready), 1);
        @(negedge clk);
        check_eq("s1_done_one_cycle", int'(done), 0);

        // Fast ramp down, step every clock.
        do_reset();
        push(125, 1); push(122, 1); push(120, 1); push(DONE_EV, HOLD);
        send_cmd(120, 0, 3);
        cur = 120;
        wait_idle("s2_idle");

        // A step of zero behaves as one.
        do_reset();
        push(129, 2); push(130, 2); push(131, 2); push(DONE_EV, HOLD);
        send_cmd(131, 1, 0);
        cur = 131;
        wait_idle("s3_idle");

        // Abort mid-ramp freezes duty and suppresses done.
        do_reset();
        push(132, 4);
        send_cmd(150, 3, 4);
        wait_duty(132);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cur = 132;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_duty", int'(duty_out), 132);
        repeat (20) @(negedge clk);
        check_eq("abort_duty_held", int'(duty_out), 132);

        // A command held during a ramp waits for IDLE. Bus changes do not
        // affect the running ramp.
        push_ramp(140, 1, 4);
        send_cmd(140, 1, 4);
        check_eq("held_ready_low", int'(cmd_ready), 0);
        push_ramp(128, 0, 2);
        send_cmd(128, 0, 2);
        wait_idle("held_idle");
        repeat (20) @(negedge clk);
        check_eq("held_once_busy", int'(busy), 0);

        // Reset mid-ramp returns duty to centre on the next edge.
        push(136, 1); push(144, 1); push(152, 1);
        send_cmd(200, 0, 8);
        wait_duty(152);
        rst = 1'b1;
        push(128, 1);
        @(negedge clk);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_ready", int'(cmd_ready), 0);
        check_eq("midrst_duty", int'(duty_out), 128);
        rst = 1'b0;
        cur = 128;
        @(negedge clk);
        check_eq("midrst_ready_after", int'(cmd_ready), 1);

        // Rails and clamping.
        push_ramp(250, 0, 15);
        send_cmd(250, 0, 15);
        check_eq("limit_250", int'(limit_hit), (clamp_model(250) != 250) ? 1 : 0);
        wait_idle("lim250_idle");
        push_ramp(0, 0, 15);
        send_cmd(0, 0, 15);
        check_eq("limit_0", int'(limit_hit), (clamp_model(0) != 0) ? 1 : 0);
        wait_idle("lim0_idle");
        push_ramp(255, 0, 15);
        send_cmd(255, 0, 15);
        check_eq("limit_255", int'(limit_hit), (clamp_model(255) != 255) ? 1 : 0);
        wait_idle("lim255_idle");
        push_ramp(100, 0, 15);
        send_cmd(100, 0, 15);
        check_eq("limit_100", int'(limit_hit), 0);
        wait_idle("lim100_idle");

        // Target equal to current duty goes straight to HOLD.
        push(DONE_EV, HOLD);
        send_cmd(100, 5, 3);
        check_eq("same_busy", int'(busy), 1);
        wait_idle("same_idle");

        // Abort in IDLE is ignored and does not block an accept.
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_abort_busy", int'(busy), 0);
        push_ramp(110, 0, 5);
        send_cmd(110, 0, 5);
        abort = 1'b0;
        check_eq("abort_accept_busy", int'(busy), 1);
        wait_idle("abort_accept_idle");

        repeat (5) @(negedge clk);
        check_eq("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
